// File: rtl/fifo_pkg.sv
// Shared definitions for the readout-path FIFO family.
// Optional feature macro: FIFO_DROP_CNT_EN (rejected-write counter).
package fifo_pkg;

    // Default event-word width used across the readout path
    localparam int DATA_W_DEF = 36;

    // Rejected-write counter width and its saturation value
    localparam int             DROP_W   = 16;
    localparam logic [15:0]    DROP_SAT = 16'hFFFF;

    // Number of words addressed by an ADDR_W-bit address
    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// Storage array for fifo_sync_param: one write port with enable and an
// asynchronous read port. Contents are never reset.
module fifo_sync_mem #(
    parameter int DATA_W = 36,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_reg [2**ADDR_W];

    // Write the addressed word when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    // Show-ahead read: the head word is presented without a clock
    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with show-ahead read, occupancy count,
// full/empty/almost-full flags and sticky overflow/underflow flags.
// Optional feature macro: FIFO_DROP_CNT_EN adds a saturating drop_cnt port.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = 3,
    parameter int AFULL_LVL = 6
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic              winc,
    input  logic [DATA_W-1:0] wdata,
    output logic              wfull,
    output logic              walmost_full,
    input  logic              rinc,
    output logic [DATA_W-1:0] rdata,
    output logic              rempty,
    output logic [ADDR_W:0]   rcount,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
`ifdef FIFO_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0] drop_cnt
`endif
);

    // DEPTH is exactly the MSB of an (ADDR_W+1)-bit value
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] AFULL_C = AFULL_LVL[ADDR_W:0];

    logic [ADDR_W:0] wptr_reg;
    logic [ADDR_W:0] rptr_reg;
    logic [ADDR_W:0] count_reg;
    logic [ADDR_W:0] count_next;
    logic            overflow_reg;
    logic            underflow_reg;
    logic            ra;
    logic            wa;
    logic            write_rejected;
    logic            read_rejected;

    // Accepts are qualified by reset so requests in the reset cycle are dropped;
    // a write into a full FIFO is allowed when a read frees a slot this cycle.
    assign ra             = wrst_n && rinc && (count_reg != '0);
    assign wa             = wrst_n && winc && ((count_reg != DEPTH_C) || ra);
    assign write_rejected = winc && !wa;
    assign read_rejected  = rinc && !ra;

    fifo_sync_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (wclk),
        .we    (wa),
        .waddr (wptr_reg[ADDR_W-1:0]),
        .wdata (wdata),
        .raddr (rptr_reg[ADDR_W-1:0]),
        .rdata (rdata)
    );

    // Next occupancy: simultaneous accepts cancel out
    always_comb begin
        count_next = count_reg;
        if (wa && !ra) begin
            count_next = count_reg + ONE_C;
        end else if (ra && !wa) begin
            count_next = count_reg - ONE_C;
        end
    end

    // Pointers, occupancy and sticky error flags; err_clr beats a same-cycle set
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wa) begin
                wptr_reg <= wptr_reg + ONE_C;
            end
            if (ra) begin
                rptr_reg <= rptr_reg + ONE_C;
            end
            count_reg <= count_next;
            if (err_clr) begin
                overflow_reg  <= 1'b0;
                underflow_reg <= 1'b0;
            end else begin
                if (write_rejected) begin
                    overflow_reg <= 1'b1;
                end
                if (read_rejected) begin
                    underflow_reg <= 1'b1;
                end
            end
        end
    end

`ifdef FIFO_DROP_CNT_EN
    logic [DROP_W-1:0] drop_cnt_reg;

    // Saturating count of rejected writes; cleared by reset or err_clr
    always_ff @(posedge wclk) begin
        if (!wrst_n || err_clr) begin
            drop_cnt_reg <= '0;
        end else if (write_rejected && (drop_cnt_reg != DROP_SAT)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`endif

    // Flags come only from the count register, so they are glitch-free
    assign rcount       = count_reg;
    assign rempty       = (count_reg == '0);
    assign wfull        = (count_reg == DEPTH_C);
    assign walmost_full = (count_reg >= AFULL_C);
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param (default parameters).
// Drop-counter checks are included when FIFO_DROP_CNT_EN is defined.
module tb_fifo_sync_param;

    localparam int DW    = 36;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AFL   = 6;

    logic          wclk = 1'b0;
    logic          wrst_n = 1'b0;
    logic          winc = 1'b0;
    logic          rinc = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          wfull;
    logic          walmost_full;
    logic [DW-1:0] rdata;
    logic          rempty;
    logic [AW:0]   rcount;
    logic          overflow;
    logic          underflow;
`ifdef FIFO_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: a queue of stored words plus flag state
    logic [DW-1:0] mq[$];
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;
    int            m_drop = 0;

    typedef struct {
        logic          w;
        logic          r;
        logic [DW-1:0] d;
        int            exp_count;
        logic [DW-1:0] exp_rdata;
        logic          exp_empty;
    } vec_t;

    vec_t vt[6];

    fifo_sync_param #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .AFULL_LVL (AFL)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wdata        (wdata),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .rinc         (rinc),
        .rdata        (rdata),
        .rempty       (rempty),
        .rcount       (rcount),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
`ifdef FIFO_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m_rcount", 64'(rcount), 64'(mq.size()));
        chk("m_rempty", 64'(rempty), 64'(mq.size() == 0));
        chk("m_wfull", 64'(wfull), 64'(mq.size() == DEPTH));
        chk("m_afull", 64'(walmost_full), 64'(mq.size() >= AFL));
        chk("m_overflow", 64'(overflow), 64'(m_ovf));
        chk("m_underflow", 64'(underflow), 64'(m_udf));
        if (mq.size() != 0) begin
            chk("m_rdata", 64'(rdata), 64'(mq[0]));
        end
`ifdef FIFO_DROP_CNT_EN
        chk("m_drop_cnt", 64'(drop_cnt), 64'(m_drop));
`endif
    endtask

    // Apply one cycle of inputs, advance the model, then check all outputs
    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d,
                         input logic clr, input logic rst_n);
        bit ra;
        bit wa;
        winc    = w;
        rinc    = r;
        wdata   = d;
        err_clr = clr;
        wrst_n  = rst_n;
        @(posedge wclk);
        if (!rst_n) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            m_drop = 0;
        end else begin
            ra = r && (mq.size() > 0);
            wa = w && ((mq.size() < DEPTH) || ra);
            if (ra) void'(mq.pop_front());
            if (wa) mq.push_back(d);
            if (clr) begin
                m_ovf  = 1'b0;
                m_udf  = 1'b0;
                m_drop = 0;
            end else begin
                if (w && !wa) begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
                if (r && !ra) m_udf = 1'b1;
            end
        end
        #1;
        check_model();
    endtask

    initial begin
        logic [DW-1:0] last_head;

        vt[0] = '{1'b1, 1'b0, 36'h1, 1, 36'h1, 1'b0};
        vt[1] = '{1'b1, 1'b0, 36'h2, 2, 36'h1, 1'b0};
        vt[2] = '{1'b1, 1'b0, 36'h3, 3, 36'h1, 1'b0};
        vt[3] = '{1'b0, 1'b1, 36'h0, 2, 36'h2, 1'b0};
        vt[4] = '{1'b0, 1'b1, 36'h0, 1, 36'h3, 1'b0};
        vt[5] = '{1'b0, 1'b1, 36'h0, 0, 36'h0, 1'b1};

        // Reset state
        cycle(1'b1, 1'b1, 36'h9, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 36'h0, 1'b0, 1'b1);
        chk("rst_rempty", 64'(rempty), 64'd1);
        chk("rst_wfull", 64'(wfull), 64'd0);
        chk("rst_afull", 64'(walmost_full), 64'd0);
        chk("rst_rcount", 64'(rcount), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_underflow", 64'(underflow), 64'd0);

        // Basic write-3 / read-3 table
        for (int i = 0; i < 6; i++) begin
            cycle(vt[i].w, vt[i].r, vt[i].d, 1'b0, 1'b1);
            chk("tbl_rcount", 64'(rcount), 64'(vt[i].exp_count));
            chk("tbl_rempty", 64'(rempty), 64'(vt[i].exp_empty));
            if (!vt[i].exp_empty) chk("tbl_rdata", 64'(rdata), 64'(vt[i].exp_rdata));
        end

        // Fill to full: almost-full after the 6th write, full after the 8th
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, DW'(36'h100 + i), 1'b0, 1'b1);
            chk("fill_afull", 64'(walmost_full), 64'(i >= AFL - 1));
            chk("fill_wfull", 64'(wfull), 64'(i == DEPTH - 1));
        end
        cycle(1'b1, 1'b0, 36'hDEAD, 1'b0, 1'b1);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_rcount", 64'(rcount), 64'd8);
        chk("ovf_head", 64'(rdata), 64'h100);
`ifdef FIFO_DROP_CNT_EN
        chk("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
`endif

        // Full with simultaneous write and read
        cycle(1'b1, 1'b1, 36'hBEEF, 1'b0, 1'b1);
        chk("full_rw_rcount", 64'(rcount), 64'd8);
        last_head = '0;
        for (int i = 0; i < DEPTH; i++) begin
            last_head = rdata;
            cycle(1'b0, 1'b1, 36'h0, 1'b0, 1'b1);
        end
        chk("drain_last", 64'(last_head), 64'hBEEF);
        chk("drain_empty", 64'(rempty), 64'd1);

        cycle(1'b0, 1'b0, 36'h0, 1'b1, 1'b1);
        chk("clr_overflow", 64'(overflow), 64'd0);

        // Empty with simultaneous write and read
        cycle(1'b1, 1'b1, 36'h55, 1'b0, 1'b1);
        chk("empty_rw_udf", 64'(underflow), 64'd1);
        chk("empty_rw_rcount", 64'(rcount), 64'd1);
        chk("empty_rw_rdata", 64'(rdata), 64'h55);
        cycle(1'b0, 1'b1, 36'h0, 1'b0, 1'b1);

        // Pointer wrap with 20 write/read pairs
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, DW'(36'h2000 + i), 1'b0, 1'b1);
            chk("wrap_rdata", 64'(rdata), 64'(36'h2000 + i));
            chk("wrap_wfull", 64'(wfull), 64'd0);
            cycle(1'b0, 1'b1, 36'h0, 1'b0, 1'b1);
            chk("wrap_rempty", 64'(rempty), 64'd1);
        end

        // err_clr coinciding with a new overflow: clear wins
        cycle(1'b0, 1'b0, 36'h0, 1'b1, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'(36'h300 + i), 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 36'hF00D, 1'b1, 1'b1);
        chk("clr_wins_ovf", 64'(overflow), 64'd0);
        chk("clr_wins_rcount", 64'(rcount), 64'd8);

        // Reset mid-transfer with 5 words stored and winc high
        cycle(1'b1, 1'b0, 36'hBAD, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 36'h0, 1'b0, 1'b1);
        chk("pre_rst_rcount", 64'(rcount), 64'd5);
        chk("pre_rst_ovf", 64'(overflow), 64'd1);
        cycle(1'b1, 1'b0, 36'h77, 1'b0, 1'b0);
        chk("mid_rst_rcount", 64'(rcount), 64'd0);
        chk("mid_rst_rempty", 64'(rempty), 64'd1);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
`ifdef FIFO_DROP_CNT_EN
        chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  {4'($urandom), 32'($urandom)},
                  1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 63) != 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised single-clock FIFO; next generation of the 36x8 event-word buffer in the readout path.
- Adds internal pointer management, full/empty/almost-full flags, an occupancy count, sticky error flags and a show-ahead read port.
- Sits between the hit/event encoder (writer) and the serializer/readout FSM (reader).

Parameters:
- DATA_W, 36, word width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W words.
- AFULL_LVL, 6, walmost_full asserts when count >= AFULL_LVL. Legal range 1..DEPTH.

Ports:
- wclk  in  1  clock; all logic on its rising edge.
- wrst_n  in  1  synchronous, active-low reset.
- winc  in  1  write request.
- wdata  in  DATA_W  write word.
- wfull  out  1  count == DEPTH.
- walmost_full  out  1  count >= AFULL_LVL.
- rinc  in  1  read request; pops the current head word.
- rdata  out  DATA_W  head word (show-ahead); valid only while !rempty.
- rempty  out  1  count == 0.
- rcount  out  ADDR_W+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- err_clr  in  1  clears overflow and underflow.
- drop_cnt  out  16  present only with FIFO_DROP_CNT_EN.

Behaviour:
- Storage: DEPTH x DATA_W register array. No reset on the array contents.
- Pointers: wptr and rptr, each ADDR_W+1 bits. The low ADDR_W bits address the array; pointers wrap naturally modulo 2**(ADDR_W+1).
- Count: register, ADDR_W+1 bits. Flags decode combinationally from the count register only, so they are glitch-free and update one cycle after the causing edge.
- Read accept: ra = rinc && (count != 0).
- Write accept: wa = winc && ((count != DEPTH) || ra). A write is accepted while full if a read is accepted in the same cycle.
- On wa: mem[wptr[ADDR_W-1:0]] <= wdata; wptr increments.
- On ra: rptr increments.
- Count update: +1 if wa && !ra; -1 if ra && !wa; unchanged otherwise.
- rdata = mem[rptr[ADDR_W-1:0]], combinational. The word written in cycle N is visible on rdata in cycle N+1 when the FIFO was empty. No same-cycle write-through.
- Empty with winc && rinc: the read is rejected and underflow is set; the write is accepted and count becomes 1.
- Full with winc && rinc: both are accepted; count stays DEPTH and the word lands in the slot just freed.
- Full with winc only: the write is rejected, memory and pointers are unchanged, and overflow is set.
- Empty with rinc only: underflow is set; pointers are unchanged.
- err_clr has priority over a set in the same cycle: clear wins, and the event is lost.
- Reset (wrst_n == 0 at an edge, including mid-transfer): wptr = rptr = count = 0; overflow = underflow = 0; drop_cnt = 0.
- Output values after reset: rempty = 1, wfull = 0, walmost_full = 0 (AFULL_LVL >= 1), rcount = 0. rdata is undefined while rempty.
- Winc/rinc in the reset cycle are ignored.

Optional Feature:
- Macro: FIFO_DROP_CNT_EN.
- Defined: adds port drop_cnt[15:0], a counter incremented on every rejected write (winc && !wa). It saturates at 16'hFFFF, clears on err_clr or reset, and err_clr has priority.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package fifo_pkg holds:
  - localparam function for DEPTH from ADDR_W;
  - the drop-counter width (16) and its saturate value;
  - the default DATA_W = 36 used across the readout path.
- One sub-module: fifo_sync_mem, the storage array only (write port with enable, async read port). Pointer, count and flag logic stay in the top.

Test Plan:
- Reset, then write 0x1, 0x2, 0x3 on consecutive cycles, then read 3 -> rdata shows 0x1, 0x2, 0x3 in order; rcount goes 1,2,3 then 2,1,0; rempty returns to 1.
- Fill 8 words (defaults) -> walmost_full rises after the 6th write and wfull after the 8th. A 9th write of 0xDEAD is rejected: overflow = 1, drop_cnt = 1, and the head is still the first word.
- Full, then winc && rinc with wdata = 0xBEEF -> rcount stays 8; drain 8 -> the last word read is 0xBEEF.
- Empty, then winc && rinc with wdata = 0x55 -> underflow = 1, rcount = 1, rdata = 0x55 next cycle.
- Run 20 write/read pairs, more than 2*DEPTH, to wrap the pointers -> data order preserved, no false full/empty; then err_clr in the same cycle as a new overflow -> overflow = 0.
- Assert wrst_n = 0 with 5 words stored and winc high -> next cycle rcount = 0, rempty = 1, overflow = 0, drop_cnt = 0.
